// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the RV32I
// instruction-fetch stage.
package fetch_unit_pkg;

  localparam int XLEN = 32;

  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } if_id_t;

endpackage

// File: rtl/fetch_fifo.sv
// Two-entry synchronous FIFO; head is always mem0.
// Push and pop may coincide whenever count is 1 or 2.
module fetch_fifo #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic         clear,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic [1:0]   count
);

  logic [W-1:0] mem0;
  logic [W-1:0] mem1;

  assign dout = mem0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem0  <= '0;
      mem1  <= '0;
      count <= 2'd0;
    end else if (clear) begin
      count <= 2'd0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (count == 2'd0) mem0 <= din;
          else mem1 <= din;
          count <= count + 2'd1;
        end
        2'b01: begin
          mem0  <= mem1;
          count <= count - 2'd1;
        end
        2'b11: begin
          if (count == 2'd2) begin
            mem0 <= mem1;
            mem1 <= din;
          end else begin
            mem0 <= din;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// IF stage: PC, imem request channel, response
// buffering and the IF/ID register.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  input  logic            redirect_e,
  input  logic [XLEN-1:0] redirect_pc_e,
  input  logic            stall_d,
  output logic            valid_d,
  output logic [XLEN-1:0] instr_d,
  output logic [XLEN-1:0] pc_d,
  output logic [XLEN-1:0] pc_plus4_d
);

  logic [XLEN-1:0] pc_f;
  logic [1:0]      outstanding;
  logic [1:0]      drop_cnt;
  logic [1:0]      aq_count;
  logic [1:0]      iq_count;
  logic [XLEN-1:0] aq_head;
  fetch_entry_t    iq_head;
  fetch_entry_t    iq_din;
  if_id_t          if_id;

  logic       req_fire;
  logic       rsp_keep;
  logic       aq_pop;
  logic       load_ifid;
  logic       pop_now;
  logic       bubble_now;
  logic [2:0] credit;

  assign load_ifid  = !stall_d || !if_id.valid;
  assign pop_now    = !redirect_e && load_ifid
                      && (iq_count != 2'd0);
  assign bubble_now = load_ifid && !pop_now;

  // Outstanding requests plus buffered words never exceed two.
  assign credit = {1'b0, outstanding}
                  + {1'b0, iq_count}
                  - {2'b00, pop_now};

  assign imem_req_valid = rst_n && !redirect_e
                          && (credit < 3'd2);
  assign imem_req_addr  = pc_f;
  assign req_fire       = imem_req_valid && imem_req_ready;

  assign rsp_keep = imem_rsp_valid && !redirect_e
                    && (drop_cnt == 2'd0);
  assign aq_pop   = imem_rsp_valid && (aq_count != 2'd0);
  assign iq_din   = '{pc: aq_head, instr: imem_rsp_data};

  fetch_fifo #(.W(XLEN)) u_addr_q (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (req_fire),
    .pop   (aq_pop),
    .clear (1'b0),
    .din   (pc_f),
    .dout  (aq_head),
    .count (aq_count)
  );

  fetch_fifo #(.W($bits(fetch_entry_t))) u_instr_q (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (rsp_keep),
    .pop   (pop_now),
    .clear (redirect_e),
    .din   (iq_din),
    .dout  (iq_head),
    .count (iq_count)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_f        <= RESET_PC;
      outstanding <= 2'd0;
      drop_cnt    <= 2'd0;
    end else begin
      outstanding <= outstanding
                     + {1'b0, req_fire}
                     - {1'b0, imem_rsp_valid};
      if (redirect_e) begin
        pc_f     <= redirect_pc_e & ~32'd3;
        drop_cnt <= outstanding - {1'b0, imem_rsp_valid};
      end else begin
        if (req_fire) pc_f <= pc_f + 32'd4;
        if (imem_rsp_valid && drop_cnt != 2'd0)
          drop_cnt <= drop_cnt - 2'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      if_id <= '{valid: 1'b0, pc: '0, instr: NOP_INSTR};
    end else begin
      unique case (1'b1)
        redirect_e || bubble_now:
          if_id <= '{valid: 1'b0, pc: if_id.pc,
                     instr: NOP_INSTR};
        pop_now:
          if_id <= '{valid: 1'b1, pc: iq_head.pc,
                     instr: iq_head.instr};
        default: ;
      endcase
    end
  end

  assign valid_d    = if_id.valid;
  assign instr_d    = if_id.instr;
  assign pc_d       = if_id.pc;
  assign pc_plus4_d = if_id.pc + 32'd4;

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage of the five-stage RV32I pipeline; it is the producer side of the IF/ID interface that the decode stage consumes. It holds the PC, issues requests to instruction memory over a valid/ready channel, and absorbs in-order responses in a 2-entry buffer. It presents one instruction per cycle in the IF/ID register, honours decode stalls, and discards wrong-path fetches on an execute-stage redirect.

## Interface
- `RESET_PC`, 32'h0000_0000, first fetch address after reset
- `clk`  in  1  clock
- `rst_n`  in  1  asynchronous, active-low reset
- `imem_req_valid`  out  1  fetch request valid
- `imem_req_ready`  in  1  memory accepts the request this cycle
- `imem_req_addr`  out  32  word-aligned fetch address
- `imem_rsp_valid`  in  1  response valid; always accepted, strictly in request order, at least 1 cycle after acceptance
- `imem_rsp_data`  in  32  instruction word
- `redirect_e`  in  1  taken branch or jump resolved in execute
- `redirect_pc_e`  in  32  redirect target; bits [1:0] are forced to 0
- `stall_d`  in  1  decode cannot accept; hold IF/ID
- `valid_d`  out  1  IF/ID holds a real instruction
- `instr_d`  out  32  instruction word; `NOP_INSTR` when `valid_d`=0
- `pc_d`  out  32  PC of `instr_d`
- `pc_plus4_d`  out  32  `pc_d` + 4, modulo 2^32

## Operation
- Registers: `pc_f`, `outstanding` (0..2), `drop_cnt` (0..2), 2-entry address queue (PC of each accepted request), 2-entry instruction FIFO of {pc, instr}, IF/ID register.
- Issue: `imem_req_valid`=1 when `redirect_e`=0 and `outstanding` + `fifo_count` − `pop_now` < 2. `imem_req_addr` = `pc_f`. On handshake, `pc_f` += 4 (wraps at 2^32), the PC is pushed to the address queue, and `outstanding`++.
- Response: `outstanding`−−. If `drop_cnt` > 0, the response is discarded and `drop_cnt`−− is applied. Otherwise {address-queue head, data} is pushed to the FIFO.
- IF/ID load (`pop_now`): when `stall_d`=0 or `valid_d`=0, the head is loaded if the FIFO is non-empty, otherwise a bubble is loaded (`valid_d`=0, `instr_d`=`NOP_INSTR`). When `stall_d`=1 and `valid_d`=1, all IF/ID outputs hold.
- Redirect: this is the highest priority, and it overrides `stall_d`.
  - `pc_f` <= aligned `redirect_pc_e`.
  - The FIFO is cleared and IF/ID is loaded with a bubble.
  - `drop_cnt` <= `outstanding` − (response this cycle ? 1 : 0). A response arriving in the redirect cycle is itself discarded.
  - No request is issued in the redirect cycle. The address queue keeps entries only for pending drops.
- Mode is implicit. RUN when `drop_cnt`=0. DRAIN when `drop_cnt`>0. New-path requests may issue during DRAIN, subject to credit.
- Credit limit: `outstanding` + `fifo_count` never exceeds 2, so the FIFO never overflows and no response is ever back-pressured.

## Timing
- Reset values:
  - `imem_req_valid`=0, `valid_d`=0, `instr_d`=`NOP_INSTR`, `pc_d`=0, `pc_plus4_d`=4.
  - `pc_f`=`RESET_PC`, all counters and queues empty.
- The first request is asserted in the first cycle after `rst_n` rises.
- A response in cycle N enters the FIFO at the end of N and appears on `valid_d` in cycle N+2 if IF/ID is free.
- With 1-cycle memory and `imem_req_ready`=1, the block sustains one instruction per cycle.
- A redirect in cycle R produces `valid_d`=0 in R+1 and a target request in R+1. The target instruction appears on `valid_d` no earlier than R+4 (1-cycle memory).
- Reset asserted mid-operation clears everything immediately. In-flight memory responses after reset are the memory's responsibility (memory is reset together with this block).

## Structure
- Shared package holds `NOP_INSTR` = 32'h0000_0013 (addi x0,x0,0), `XLEN`=32, and the default `RESET_PC`.
- Sub-module `fetch_fifo`: 2-entry synchronous FIFO with push, pop, clear, count, and a same-cycle push+pop when full-minus-one. It is instantiated for both the address queue and the instruction FIFO.

## Test plan
- Reset release, memory ready with latency 1:
  - Requests go to 0x0, 0x4, 0x8 on consecutive cycles.
  - `valid_d` shows pc 0x0, 0x4, 0x8 back-to-back from cycle 3.
  - `pc_plus4_d`=`pc_d`+4.
- `stall_d` held for 3 cycles while `pc_d`=0x4:
  - `pc_d`/`instr_d` are held.
  - `outstanding`+`fifo_count` is ≤2 throughout.
  - No response is lost, and 0x8 and 0xC follow in order.
- `redirect_e`=1 with `redirect_pc_e`=0x103 while 2 requests are outstanding and `stall_d`=1:
  - Both responses are dropped and `valid_d`=0 next cycle.
  - The next request address is 0x100, and the first valid `pc_d` is 0x100.
- Response arrives in the same cycle as the redirect: it is discarded and `drop_cnt`=1.
- `imem_req_ready`=0 for 5 cycles: `imem_req_addr` is stable, `pc_f` is unchanged, and bubbles carry `instr_d`=0x0000_0013.
- `RESET_PC`=0xFFFF_FFFC:
  - The fetch sequence wraps to 0x0.
  - `pc_plus4_d` of 0xFFFF_FFFC is 0x0.
  - Asserting `rst_n`=0 mid-stream zeroes `valid_d` asynchronously.
